// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss interfaces.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-cache priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_strobe,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_strobe,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_rw,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_done,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_strobe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rw,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  ic_pend_q, ic_pend_d;
  logic                  dc_pend_q, dc_pend_d;
  logic [ADDR_WIDTH-1:0] ic_addr_q, ic_addr_d;
  logic [ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
  logic                  dc_rw_q, dc_rw_d;
  logic [LINE_WIDTH-1:0] dc_wdata_q, dc_wdata_d;
  logic                  mem_strobe_q, mem_strobe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ic_done_q, ic_done_d;
  logic                  dc_done_q, dc_done_d;
  logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_WIDTH-1:0] dc_rdata_q, dc_rdata_d;

  logic ic_avail, dc_avail, do_grant, grant_sel, tie_sel;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ic_pend_d    = ic_pend_q;
    dc_pend_d    = dc_pend_q;
    ic_addr_d    = ic_addr_q;
    dc_addr_d    = dc_addr_q;
    dc_rw_d      = dc_rw_q;
    dc_wdata_d   = dc_wdata_q;
    mem_strobe_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_rw_d     = mem_rw_q;
    mem_wdata_d  = mem_wdata_q;
    ic_done_d    = 1'b0;
    dc_done_d    = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    do_grant     = 1'b0;

    if (ic_strobe && !ic_pend_q) begin
      ic_pend_d = 1'b1;
      ic_addr_d = ic_addr;
    end
    if (dc_strobe && !dc_pend_q) begin
      dc_pend_d  = 1'b1;
      dc_addr_d  = dc_addr;
      dc_rw_d    = dc_rw;
      dc_wdata_d = dc_wdata;
    end

    // The owner being retired in RESP no longer competes for the next grant.
    ic_avail = ic_pend_q && !(state_q == S_RESP && owner_q == OWN_IC);
    dc_avail = dc_pend_q && !(state_q == S_RESP && owner_q == OWN_DC);

`ifdef MEM_ARB_RR_EN
    tie_sel = ~last_grant_q;
`else
    tie_sel = OWN_DC;
`endif
    if (ic_avail && dc_avail) grant_sel = tie_sel;
    else if (dc_avail)        grant_sel = OWN_DC;
    else                      grant_sel = OWN_IC;

    case (state_q)
      S_IDLE: begin
        if (ic_avail || dc_avail) do_grant = 1'b1;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          state_d = S_RESP;
          if (owner_q == OWN_IC) begin
            ic_done_d  = 1'b1;
            ic_rdata_d = mem_rdata;
          end else begin
            dc_done_d = 1'b1;
            if (!dc_rw_q) dc_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        if (owner_q == OWN_IC) ic_pend_d = 1'b0;
        else                   dc_pend_d = 1'b0;
        if (ic_avail || dc_avail) do_grant = 1'b1;
        else                      state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_grant) begin
      state_d      = S_ISSUE;
      owner_d      = grant_sel;
      last_grant_d = grant_sel;
      mem_strobe_d = 1'b1;
      if (grant_sel == OWN_IC) begin
        mem_addr_d  = ic_addr_q;
        mem_rw_d    = 1'b0;
        mem_wdata_d = '0;
      end else begin
        mem_addr_d  = dc_addr_q;
        mem_rw_d    = dc_rw_q;
        mem_wdata_d = dc_wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_DC;
      ic_pend_q    <= 1'b0;
      dc_pend_q    <= 1'b0;
      ic_addr_q    <= '0;
      dc_addr_q    <= '0;
      dc_rw_q      <= 1'b0;
      dc_wdata_q   <= '0;
      mem_strobe_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rw_q     <= 1'b0;
      mem_wdata_q  <= '0;
      ic_done_q    <= 1'b0;
      dc_done_q    <= 1'b0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ic_pend_q    <= ic_pend_d;
      dc_pend_q    <= dc_pend_d;
      ic_addr_q    <= ic_addr_d;
      dc_addr_q    <= dc_addr_d;
      dc_rw_q      <= dc_rw_d;
      dc_wdata_q   <= dc_wdata_d;
      mem_strobe_q <= mem_strobe_d;
      mem_addr_q   <= mem_addr_d;
      mem_rw_q     <= mem_rw_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_done_q    <= ic_done_d;
      dc_done_q    <= dc_done_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  assign mem_strobe = mem_strobe_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rw     = mem_rw_q;
  assign mem_wdata  = mem_wdata_q;
  assign ic_done    = ic_done_q;
  assign dc_done    = dc_done_q;
  assign ic_rdata   = ic_rdata_q;
  assign dc_rdata   = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-ported memory of programmable latency.
// Tie-break expectations follow MEM_ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ic_strobe = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_done;
  logic [LW-1:0] ic_rdata;
  logic          dc_strobe = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic          dc_rw = 1'b0;
  logic [LW-1:0] dc_wdata = '0;
  logic          dc_done;
  logic [LW-1:0] dc_rdata;
  logic          mem_strobe;
  logic [AW-1:0] mem_addr;
  logic          mem_rw;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_done;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_strobe(ic_strobe), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_strobe(dc_strobe), .dc_addr(dc_addr), .dc_rw(dc_rw), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_strobe(mem_strobe), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int lat = 2;
  int n_strobe = 0, n_ic = 0, n_dc = 0, ic_done_cyc = 0;
  logic [AW-1:0] grant_log[$];
  logic          grant_rw[$];
  logic          held_ok = 1'b0;
  logic [AW-1:0] st_addr;
  logic          st_rw;
  logic [LW-1:0] st_wdata = '0;

  localparam logic [LW-1:0] JUNK = {8{32'hDEAD_BEEF}};

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory: answers each strobe exactly lat cycles later and watches the request stay stable.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = JUNK;
    forever begin
      @(posedge clk); #1;
      if (mem_strobe === 1'b1) begin
        st_addr = mem_addr; st_rw = mem_rw; st_wdata = mem_wdata; held_ok = 1'b1;
        repeat (lat) begin
          @(posedge clk); #1;
          if (mem_addr !== st_addr || mem_rw !== st_rw || mem_wdata !== st_wdata) held_ok = 1'b0;
        end
        mem_done  = 1'b1;
        mem_rdata = line_of(st_addr);
        @(posedge clk); #1;
        mem_done  = 1'b0;
        mem_rdata = JUNK;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_strobe === 1'b1) begin
        n_strobe++;
        grant_log.push_back(mem_addr);
        grant_rw.push_back(mem_rw);
      end
      if (ic_done === 1'b1) begin n_ic++; ic_done_cyc = cyc; end
      if (dc_done === 1'b1) n_dc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    n_strobe = 0; n_ic = 0; n_dc = 0;
    grant_log.delete();
    grant_rw.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_strobe = 1'b0; dc_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int it, input int dt, output bit timed_out);
    int k;
    k = 0;
    while ((n_ic < it || n_dc < dt) && k < 200) begin
      @(posedge clk);
      k++;
    end
    timed_out = (k >= 200);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_strobe, mem_rw, ic_done, dc_done} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b required 0000", {mem_strobe, mem_rw, ic_done, dc_done});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_mem_bus: addr %h wdata %h required 0", mem_addr, mem_wdata);
    end
    checks++;
    if (ic_rdata !== '0 || dc_rdata !== '0) begin
      failures++; $display("FAIL reset_rdata: ic %h dc %h required 0", ic_rdata, dc_rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_strobe !== 0) begin
      failures++; $display("FAIL reset_idle_strobe: got %0d strobes required 0", n_strobe);
    end
  endtask

  task automatic test_single_iread();
    bit to;
    int t0;
    do_reset();
    clear_counts();
    lat = 2;
    @(posedge clk); #1;
    ic_strobe = 1'b1; ic_addr = 32'h0000_1000; t0 = cyc;
    @(posedge clk); #1;
    ic_strobe = 1'b0; ic_addr = 32'hFFFF_FFFF;
    wait_done(1, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL iread_timeout: ic_done count %0d required 1", n_ic); end
    checks++;
    if (n_strobe !== 1) begin failures++; $display("FAIL iread_strobes: got %0d required 1", n_strobe); end
    checks++;
    if (grant_log.size() < 1 || grant_log[0] !== 32'h0000_1000 || grant_rw[0] !== 1'b0) begin
      failures++; $display("FAIL iread_addr: got %h required 00001000 read", grant_log.size() > 0 ? grant_log[0] : 'x);
    end
    checks++;
    if (ic_done_cyc - t0 !== 5) begin
      failures++; $display("FAIL iread_latency: got %0d required 5", ic_done_cyc - t0);
    end
    checks++;
    if (ic_rdata !== line_of(32'h0000_1000)) begin
      failures++; $display("FAIL iread_data: got %h required %h", ic_rdata, line_of(32'h0000_1000));
    end
    checks++;
    if (n_ic !== 1 || n_dc !== 0) begin
      failures++; $display("FAIL iread_done_count: ic %0d dc %0d required 1 0", n_ic, n_dc);
    end
  endtask

  task automatic test_dc_write();
    bit to;
    clear_counts();
    @(posedge clk); #1;
    dc_strobe = 1'b1; dc_rw = 1'b1; dc_addr = 32'h0000_2000; dc_wdata = {32{8'hA5}};
    @(posedge clk); #1;
    dc_strobe = 1'b0; dc_rw = 1'b0; dc_addr = 32'hFFFF_FFFF; dc_wdata = '0;
    wait_done(0, 1, to);
    checks++;
    if (to) begin failures++; $display("FAIL dwrite_timeout: dc_done count %0d required 1", n_dc); end
    checks++;
    if (n_strobe !== 1 || grant_log.size() < 1 || grant_log[0] !== 32'h0000_2000 || grant_rw[0] !== 1'b1) begin
      failures++; $display("FAIL dwrite_req: strobes %0d addr %h required 1 00002000 write", n_strobe, grant_log.size() > 0 ? grant_log[0] : 'x);
    end
    checks++;
    if (st_wdata !== {32{8'hA5}} || held_ok !== 1'b1) begin
      failures++; $display("FAIL dwrite_wdata_held: wdata %h held %b required a5.. 1", st_wdata, held_ok);
    end
    checks++;
    if (dc_rdata !== '0) begin
      failures++; $display("FAIL dwrite_rdata_unchanged: got %h required 0", dc_rdata);
    end
    checks++;
    if (n_dc !== 1 || n_ic !== 0) begin
      failures++; $display("FAIL dwrite_done_count: dc %0d ic %0d required 1 0", n_dc, n_ic);
    end
    checks++;
    if (ic_rdata !== line_of(32'h0000_1000)) begin
      failures++; $display("FAIL ic_rdata_hold: got %h required %h", ic_rdata, line_of(32'h0000_1000));
    end
  endtask

  task automatic test_dc_read();
    bit to;
    clear_counts();
    @(posedge clk); #1;
    dc_strobe = 1'b1; dc_rw = 1'b0; dc_addr = 32'h0000_3000;
    @(posedge clk); #1;
    dc_strobe = 1'b0; dc_addr = '0;
    wait_done(0, 1, to);
    checks++;
    if (to || n_dc !== 1 || n_ic !== 0) begin
      failures++; $display("FAIL dread_done: dc %0d ic %0d required 1 0", n_dc, n_ic);
    end
    checks++;
    if (dc_rdata !== line_of(32'h0000_3000)) begin
      failures++; $display("FAIL dread_data: got %h required %h", dc_rdata, line_of(32'h0000_3000));
    end
  endtask

  task automatic test_simultaneous();
    bit to;
    logic [AW-1:0] first_exp, second_exp;
`ifdef MEM_ARB_RR_EN
    first_exp = 32'h0000_0100; second_exp = 32'h0000_0200;
`else
    first_exp = 32'h0000_0200; second_exp = 32'h0000_0100;
`endif
    do_reset();
    clear_counts();
    @(posedge clk); #1;
    ic_strobe = 1'b1; ic_addr = 32'h0000_0100;
    dc_strobe = 1'b1; dc_addr = 32'h0000_0200; dc_rw = 1'b0;
    @(posedge clk); #1;
    ic_strobe = 1'b0; dc_strobe = 1'b0;
    wait_done(1, 1, to);
    checks++;
    if (to || n_strobe !== 2) begin
      failures++; $display("FAIL simul_strobes: got %0d required 2", n_strobe);
    end
    checks++;
    if (grant_log.size() < 2 || grant_log[0] !== first_exp || grant_log[1] !== second_exp) begin
      failures++; $display("FAIL simul_order: got %h,%h required %h,%h",
        grant_log.size() > 0 ? grant_log[0] : 'x, grant_log.size() > 1 ? grant_log[1] : 'x, first_exp, second_exp);
    end
    checks++;
    if (ic_rdata !== line_of(32'h0000_0100) || dc_rdata !== line_of(32'h0000_0200)) begin
      failures++; $display("FAIL simul_data: ic %h dc %h", ic_rdata, dc_rdata);
    end
  endtask

  task automatic test_repeat_strobe();
    bit to;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ic_strobe = 1'b1; ic_addr = 32'h0000_0400 + i * 32'h100;
    end
    @(posedge clk); #1;
    ic_strobe = 1'b0;
    wait_done(1, 0, to);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (to || n_strobe !== 1 || n_ic !== 1) begin
      failures++; $display("FAIL repeat_single_issue: strobes %0d ic_done %0d required 1 1", n_strobe, n_ic);
    end
    checks++;
    if (ic_rdata !== line_of(32'h0000_0400)) begin
      failures++; $display("FAIL repeat_first_addr: got %h required %h", ic_rdata, line_of(32'h0000_0400));
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    lat = 4;
    @(posedge clk); #1;
    ic_strobe = 1'b1; ic_addr = 32'h0000_0800;
    @(posedge clk); #1;
    ic_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_strobe, mem_rw, ic_done, dc_done} !== 4'b0 || mem_addr !== '0 || ic_rdata !== '0 || dc_rdata !== '0) begin
      failures++; $display("FAIL midreset_outputs: addr %h ic_rdata %h required 0", mem_addr, ic_rdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (n_ic !== 0 || n_dc !== 0) begin
      failures++; $display("FAIL midreset_late_done: ic %0d dc %0d required 0 0", n_ic, n_dc);
    end
    checks++;
    if (n_strobe !== 1 || ic_rdata !== '0) begin
      failures++; $display("FAIL midreset_state: strobes %0d ic_rdata %h required 1 0", n_strobe, ic_rdata);
    end
    lat = 2;
  endtask

  task automatic test_rr_starvation();
    bit to;
    int ns0, idx;
    clear_counts();
    ns0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      dc_strobe = 1'b1; dc_rw = 1'b0; dc_addr = 32'h0000_4000 + i * 32'h20;
      if (i == 7) begin
        ic_strobe = 1'b1; ic_addr = 32'h0000_9000; ns0 = n_strobe;
      end else begin
        ic_strobe = 1'b0;
      end
    end
    @(posedge clk); #1;
    dc_strobe = 1'b0; ic_strobe = 1'b0;
    wait_done(1, 0, to);
    repeat (20) @(posedge clk);
    #1;
    idx = -1;
    for (int j = 0; j < grant_log.size(); j++)
      if (idx < 0 && grant_log[j] === 32'h0000_9000) idx = j;
    checks++;
    if (to || n_ic !== 1) begin
      failures++; $display("FAIL starve_ic_done: got %0d required 1", n_ic);
    end
    checks++;
    if (idx < ns0 || idx - ns0 > 1) begin
      failures++; $display("FAIL starve_grant_wait: I granted at %0d, strobed after %0d grants, required within 2", idx, ns0);
    end
  endtask

  initial begin
    test_reset();
    test_single_iread();
    test_dc_write();
    test_dc_read();
    test_simultaneous();
    test_repeat_strobe();
    test_reset_mid();
    test_rr_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
